// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// Registered decode stage between register read and the execute-stage ALU.
// Turns a decoded RV32I instruction word, together with the register-file
// read data, the PC and the pre-formatted immediate, into the ALU operation
// code and its two operands. The stage holds a single entry behind a
// valid/ready handshake. It supports a flush, and it marks instructions that
// have no ALU mapping as illegal. Illegal entries still travel down the
// pipe.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   InstrD         instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
//   RD1D, RD2D     rs1 / rs2 read data
//   PCD            instruction address
//   ImmExtD        sign-extended immediate, already formatted for the type
//   InValid        upstream presents a valid instruction
//   InReady        stage can accept this cycle (!OutValid | OutReady)
//   OutValid       E-side registers hold a valid entry
//   OutReady       execute consumes the held entry this cycle
//   Flush          drop the held entry and anything accepted this cycle
//   ALUControlE    ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//   SrcAE, SrcBE   ALU operands
//   IllegalE       held entry has no ALU mapping
//   IssueCount     accepted (non-flushed) instructions
//   IllegalCount   accepted (non-flushed) illegal instructions
//
// Configuration
//   ALU_DECODE_STATS_EN  when defined, IssueCount / IllegalCount are real
//                        wrapping 32-bit counters. When not defined, both
//                        ports are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module alu_decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           InstrD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  OutValid,
  input  logic                  OutReady,
  input  logic                  Flush,
  output logic [3:0]            ALUControlE,
  output logic [DATA_WIDTH-1:0] SrcAE,
  output logic [DATA_WIDTH-1:0] SrcBE,
  output logic                  IllegalE,
  output logic [31:0]           IssueCount,
  output logic [31:0]           IllegalCount
);

  localparam int SHW = $clog2(DATA_WIDTH);

  // Shift operands keep only the low SHW bits of the shift amount.
  localparam logic [DATA_WIDTH-1:0] SHIFT_MASK = {{(DATA_WIDTH-SHW){1'b0}}, {SHW{1'b1}}};

  // Link value for JAL/JALR: the return address is PC + 4.
  localparam logic [DATA_WIDTH-1:0] LINK_OFFSET = DATA_WIDTH'(4);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_ZERO,
    SRC_A_RS1,
    SRC_A_PC
  } src_a_sel_t;

  typedef enum logic [1:0] {
    SRC_B_ZERO,
    SRC_B_RS2,
    SRC_B_IMM,
    SRC_B_LINK
  } src_b_sel_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  alu_op_t    dec_op;
  src_a_sel_t dec_a_sel;
  src_b_sel_t dec_b_sel;
  logic       dec_illegal;
  logic       dec_is_shift;

  logic [DATA_WIDTH-1:0] dec_src_a;
  logic [DATA_WIDTH-1:0] dec_src_b_raw;
  logic [DATA_WIDTH-1:0] dec_src_b;

  logic                  accept;
  logic                  out_valid_q;
  logic [3:0]            alu_control_q;
  logic [DATA_WIDTH-1:0] src_a_q;
  logic [DATA_WIDTH-1:0] src_b_q;
  logic                  illegal_q;

  // Register-specifier bits are not needed to choose the ALU operation.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  // Map from funct3 shared by OP and OP-IMM. Codes 000 and 101 also depend
  // on funct7. Each caller applies that refinement.
  function automatic alu_op_t base_alu_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction classification. This block picks the ALU operation and where
  // each operand comes from. Any encoding with no ALU meaning falls into
  // dec_illegal. At the end of the block, an illegal entry is forced to ADD
  // with both operands zero, so the execute stage sees a harmless operation.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_a_sel   = SRC_A_ZERO;
    dec_b_sel   = SRC_B_ZERO;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_a_sel = SRC_A_RS1;
        dec_b_sel = SRC_B_RS2;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     dec_op = ALU_ADD;
            else if (funct7 == F7_ALT) dec_op = ALU_SUB;
            else                       dec_illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_illegal = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE) dec_op = base_alu_op(funct3);
            else                   dec_illegal = 1'b1;
          end
        endcase
      end

      OPC_OP_IMM: begin
        dec_a_sel = SRC_A_RS1;
        dec_b_sel = SRC_B_IMM;
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) dec_op = ALU_SLL;
            else                   dec_illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_illegal = 1'b1;
          end
          default: dec_op = base_alu_op(funct3);
        endcase
      end

      OPC_LOAD, OPC_STORE: begin
        dec_a_sel = SRC_A_RS1;
        dec_b_sel = SRC_B_IMM;
      end

      OPC_BRANCH: begin
        dec_a_sel = SRC_A_RS1;
        dec_b_sel = SRC_B_RS2;
        case (funct3[2:1])
          2'b00:   dec_op = ALU_SUB;
          2'b10:   dec_op = ALU_SLT;
          2'b11:   dec_op = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        dec_a_sel = SRC_A_ZERO;
        dec_b_sel = SRC_B_IMM;
      end

      OPC_AUIPC: begin
        dec_a_sel = SRC_A_PC;
        dec_b_sel = SRC_B_IMM;
      end

      OPC_JAL: begin
        dec_a_sel = SRC_A_PC;
        dec_b_sel = SRC_B_LINK;
      end

      OPC_JALR: begin
        dec_a_sel = SRC_A_PC;
        dec_b_sel = SRC_B_LINK;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end

      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_op    = ALU_ADD;
      dec_a_sel = SRC_A_ZERO;
      dec_b_sel = SRC_B_ZERO;
    end
  end

  // Operand multiplexers. For shift operations, operand B becomes a clean
  // shift amount: only the low SHW bits survive, whether the amount came
  // from rs2 or from the immediate.
  always_comb begin
    dec_src_a = '0;
    case (dec_a_sel)
      SRC_A_RS1: dec_src_a = RD1D;
      SRC_A_PC:  dec_src_a = PCD;
      default:   dec_src_a = '0;
    endcase

    dec_src_b_raw = '0;
    case (dec_b_sel)
      SRC_B_RS2:  dec_src_b_raw = RD2D;
      SRC_B_IMM:  dec_src_b_raw = ImmExtD;
      SRC_B_LINK: dec_src_b_raw = LINK_OFFSET;
      default:    dec_src_b_raw = '0;
    endcase

    dec_is_shift = (dec_op == ALU_SLL) || (dec_op == ALU_SRL) || (dec_op == ALU_SRA);
    dec_src_b    = dec_is_shift ? (dec_src_b_raw & SHIFT_MASK) : dec_src_b_raw;
  end

  // Handshake. The single entry can be refilled in the same cycle it drains,
  // so an entry can move through every cycle while execute keeps OutReady high.
  assign InReady = !out_valid_q || OutReady;
  assign accept  = InValid && InReady;

  // Occupancy flag. Flush wins over everything, including a simultaneous
  // accept. Otherwise a new entry keeps the stage full. Otherwise a drain
  // empties it. With no event, the flag holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (Flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (OutReady) begin
      out_valid_q <= 1'b0;
    end
  end

  // Payload registers. They load only on accept, so the E-side outputs stay
  // frozen while execute is stalled. A load during a flush does no harm,
  // because the entry is marked invalid anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control_q <= 4'd0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      illegal_q     <= 1'b0;
    end else if (accept) begin
      alu_control_q <= dec_op;
      src_a_q       <= dec_src_a;
      src_b_q       <= dec_src_b;
      illegal_q     <= dec_illegal;
    end
  end

  assign OutValid    = out_valid_q;
  assign ALUControlE = alu_control_q;
  assign SrcAE       = src_a_q;
  assign SrcBE       = src_b_q;
  assign IllegalE    = illegal_q;

`ifdef ALU_DECODE_STATS_EN
  logic [31:0] issue_count_q;
  logic [31:0] illegal_count_q;

  // Statistics. An accept is counted only when it actually issues, that is,
  // when no flush throws it away in the same cycle. Both counters wrap
  // naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q   <= 32'd0;
      illegal_count_q <= 32'd0;
    end else if (accept && !Flush) begin
      issue_count_q <= issue_count_q + 32'd1;
      if (dec_illegal) begin
        illegal_count_q <= illegal_count_q + 32'd1;
      end
    end
  end

  assign IssueCount   = issue_count_q;
  assign IllegalCount = illegal_count_q;
`else
  assign IssueCount   = 32'd0;
  assign IllegalCount = 32'd0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Self-checking bench for alu_decode_stage. The sequence is:
//   - a reset check;
//   - a table of directed decode vectors streamed back-to-back;
//   - hand-written backpressure, flush, mid-entry reset and illegal-count
//     sequences;
//   - a randomized phase checked against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

  localparam int DW = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   InstrD;
  logic [DW-1:0] RD1D, RD2D, PCD, ImmExtD;
  logic          InValid, InReady, OutValid, OutReady, Flush;
  logic [3:0]    ALUControlE;
  logic [DW-1:0] SrcAE, SrcBE;
  logic          IllegalE;
  logic [31:0]   IssueCount, IllegalCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .ImmExtD(ImmExtD), .InValid(InValid), .InReady(InReady),
    .OutValid(OutValid), .OutReady(OutReady), .Flush(Flush),
    .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .IllegalE(IllegalE), .IssueCount(IssueCount), .IllegalCount(IllegalCount)
  );

  // Build an instruction word from its three decode fields. The register
  // fields are left at zero.
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  // Reference decode. It works from a funct3 lookup table plus per-opcode
  // legality rules. Shift amounts are reduced modulo the operand width.
  function automatic void ref_decode(input logic [31:0] instr, input logic [31:0] rd1,
                                     input logic [31:0] rd2, input logic [31:0] pc,
                                     input logic [31:0] imm, output logic [3:0] op,
                                     output logic [31:0] a, output logic [31:0] b,
                                     output logic ill);
    logic [3:0] f3_table [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic legal;
    f3_table = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    legal = 1'b1;
    op = OP_ADD;
    a = 32'd0;
    b = 32'd0;
    case (opc)
      7'h33: begin
        a = rd1; b = rd2; op = f3_table[f3];
        if (f7 == 7'h20 && f3 == 3'd0)      op = OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) op = OP_SRA;
        else if (f7 != 7'h00)               legal = 1'b0;
      end
      7'h13: begin
        a = rd1; b = imm; op = f3_table[f3];
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        else if (f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) op = OP_SRA;
        end
      end
      7'h03, 7'h23: begin a = rd1; b = imm; end
      7'h63: begin
        a = rd1; b = rd2;
        if (f3 == 3'd0 || f3 == 3'd1)      op = OP_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) op = OP_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) op = OP_SLTU;
        else                               legal = 1'b0;
      end
      7'h37: begin a = 32'd0; b = imm; end
      7'h17: begin a = pc; b = imm; end
      7'h6F: begin a = pc; b = 32'd4; end
      7'h67: begin a = pc; b = 32'd4; legal = (f3 == 3'd0); end
      default: legal = 1'b0;
    endcase
    if (op == OP_SLL || op == OP_SRL || op == OP_SRA) b = b % DW;
    if (!legal) begin
      op = OP_ADD; a = 32'd0; b = 32'd0;
    end
    ill = !legal;
  endfunction

  // Behavioural model of the stage: it tracks the held entry and the
  // statistics counters, using only the bench-driven inputs.
  logic [3:0]  d_op;
  logic [31:0] d_a, d_b;
  logic        d_ill;
  logic        m_valid = 1'b0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_ill = 1'b0;
  logic [31:0] m_issue = 32'd0, m_illegal = 32'd0;

  always_comb ref_decode(InstrD, RD1D, RD2D, PCD, ImmExtD, d_op, d_a, d_b, d_ill);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_issue <= 32'd0; m_illegal <= 32'd0;
    end else begin
      if (InValid && (!m_valid || OutReady)) begin
        m_op <= d_op; m_a <= d_a; m_b <= d_b; m_ill <= d_ill;
        if (!Flush) begin
          m_issue <= m_issue + 32'd1;
          if (d_ill) m_illegal <= m_illegal + 32'd1;
        end
      end
      if (Flush)                                 m_valid <= 1'b0;
      else if (InValid && (!m_valid || OutReady)) m_valid <= 1'b1;
      else if (OutReady)                          m_valid <= 1'b0;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] instr, rd1, rd2, pc, imm;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] pc,
                               input logic [31:0] imm, input logic in_valid,
                               input logic out_ready, input logic flush);
    InstrD = instr; RD1D = rd1; RD2D = rd2; PCD = pc; ImmExtD = imm;
    InValid = in_valid; OutReady = out_ready; Flush = flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkEntry(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic ill);
    checkOutput({name, "/valid"}, 32'(OutValid), 32'd1);
    checkOutput({name, "/op"}, 32'(ALUControlE), 32'(op));
    checkOutput({name, "/srca"}, SrcAE, a);
    checkOutput({name, "/srcb"}, SrcBE, b);
    checkOutput({name, "/illegal"}, 32'(IllegalE), 32'(ill));
  endtask

  task automatic checkCounters(input string name);
`ifdef ALU_DECODE_STATS_EN
    checkOutput({name, "/issue_count"}, IssueCount, m_issue);
    checkOutput({name, "/illegal_count"}, IllegalCount, m_illegal);
`else
    checkOutput({name, "/issue_count"}, IssueCount, 32'd0);
    checkOutput({name, "/illegal_count"}, IllegalCount, 32'd0);
`endif
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence followed by the randomized phase.
  initial begin
    logic [6:0]  opcs [10];
    logic [31:0] r;
    logic [6:0]  f7;
    logic [31:0] instr_a, instr_b;

    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};

    vecs[0]  = '{"sub",      mk(7'h20, 3'd0, 7'h33), 32'd5, 32'd7, 32'h0, 32'h0,
                 OP_SUB, 32'd5, 32'd7, 1'b0};
    vecs[1]  = '{"srai",     mk(7'h20, 3'd5, 7'h13), 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0423,
                 OP_SRA, 32'h8000_0000, 32'd3, 1'b0};
    vecs[2]  = '{"sll",      mk(7'h00, 3'd1, 7'h33), 32'd1, 32'hFFFF_FFE4, 32'h0, 32'h0,
                 OP_SLL, 32'd1, 32'd4, 1'b0};
    vecs[3]  = '{"auipc",    mk(7'h00, 3'd0, 7'h17), 32'h55, 32'h66, 32'h100, 32'h2000,
                 OP_ADD, 32'h100, 32'h2000, 1'b0};
    vecs[4]  = '{"jal",      mk(7'h7F, 3'd7, 7'h6F), 32'h11, 32'h22, 32'hFFFF_FFFC, 32'h800,
                 OP_ADD, 32'hFFFF_FFFC, 32'd4, 1'b0};
    vecs[5]  = '{"ill_opc",  mk(7'h00, 3'd0, 7'h73), 32'h1234, 32'h5678, 32'h40, 32'h99,
                 OP_ADD, 32'd0, 32'd0, 1'b1};
    vecs[6]  = '{"ill_br",   mk(7'h00, 3'd2, 7'h63), 32'h1234, 32'h5678, 32'h40, 32'h99,
                 OP_ADD, 32'd0, 32'd0, 1'b1};
    vecs[7]  = '{"lui",      mk(7'h09, 3'd3, 7'h37), 32'hDEAD, 32'h0, 32'h80, 32'h1234_5000,
                 OP_ADD, 32'd0, 32'h1234_5000, 1'b0};
    vecs[8]  = '{"load",     mk(7'h00, 3'd2, 7'h03), 32'h1000, 32'h0, 32'h0, 32'hFFFF_FFFC,
                 OP_ADD, 32'h1000, 32'hFFFF_FFFC, 1'b0};
    vecs[9]  = '{"bgeu",     mk(7'h00, 3'd7, 7'h63), 32'hA, 32'hB, 32'h0, 32'h10,
                 OP_SLTU, 32'hA, 32'hB, 1'b0};
    vecs[10] = '{"ill_f7",   mk(7'h01, 3'd0, 7'h33), 32'h3, 32'h4, 32'h0, 32'h0,
                 OP_ADD, 32'd0, 32'd0, 1'b1};
    vecs[11] = '{"slti",     mk(7'h7F, 3'd2, 7'h13), 32'h7, 32'h0, 32'h0, 32'hFFFF_FFFF,
                 OP_SLT, 32'h7, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{"ill_jalr", mk(7'h00, 3'd1, 7'h67), 32'h7, 32'h8, 32'h300, 32'h0,
                 OP_ADD, 32'd0, 32'd0, 1'b1};
    vecs[13] = '{"srl",      mk(7'h00, 3'd5, 7'h33), 32'hF0, 32'h25, 32'h0, 32'h0,
                 OP_SRL, 32'hF0, 32'd5, 1'b0};

    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/valid", 32'(OutValid), 32'd0);
    checkOutput("reset/op", 32'(ALUControlE), 32'd0);
    checkOutput("reset/srca", SrcAE, 32'd0);
    checkOutput("reset/srcb", SrcBE, 32'd0);
    checkOutput("reset/illegal", 32'(IllegalE), 32'd0);
    checkOutput("reset/issue_count", IssueCount, 32'd0);
    checkOutput("reset/illegal_count", IllegalCount, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset/in_ready", 32'(InReady), 32'd1);

    // Directed vectors, streamed back-to-back with execute always ready.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].rd1, vecs[i].rd2, vecs[i].pc, vecs[i].imm,
                    1'b1, 1'b1, 1'b0);
      nextCycle();
      checkEntry(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ill);
    end
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("drain/valid", 32'(OutValid), 32'd0);
    checkCounters("table");

    // Backpressure: the entry holds while execute stalls, then the next
    // entry loads on the release edge with no bubble.
    instr_a = mk(7'h00, 3'd4, 7'h33);
    instr_b = mk(7'h00, 3'd6, 7'h13);
    applyStimulus(instr_a, 32'hAAAA_0000, 32'h0000_5555, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    nextCycle();
    checkEntry("bp_load", OP_XOR, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
    applyStimulus(instr_b, 32'h0F0F_0F0F, 32'h0, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_stall/in_ready", 32'(InReady), 32'd0);
      nextCycle();
      checkEntry("bp_stall", OP_XOR, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
    end
    OutReady = 1'b1;
    #1;
    checkOutput("bp_release/in_ready", 32'(InReady), 32'd1);
    nextCycle();
    checkEntry("bp_release", OP_OR, 32'h0F0F_0F0F, 32'h0000_00F0, 1'b0);

    // Flush with a held entry and a simultaneous accept.
    applyStimulus(instr_a, 32'h1, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    nextCycle();
    checkOutput("flush/valid", 32'(OutValid), 32'd0);
    checkCounters("flush");
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("flush_idle/valid", 32'(OutValid), 32'd0);

    // Reset in the middle of a held entry drops it at once.
    applyStimulus(instr_a, 32'h77, 32'h88, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkEntry("pre_reset", OP_XOR, 32'h77, 32'h88, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset/valid", 32'(OutValid), 32'd0);
    checkOutput("async_reset/srca", SrcAE, 32'd0);
    checkOutput("async_reset/srcb", SrcBE, 32'd0);
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    rst_n = 1'b1;

    // Two illegal encodings straight after reset.
    applyStimulus(mk(7'h00, 3'd0, 7'h73), 32'h9, 32'h9, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0);
    nextCycle();
    checkEntry("ill1", OP_ADD, 32'd0, 32'd0, 1'b1);
    applyStimulus(mk(7'h00, 3'd2, 7'h63), 32'h9, 32'h9, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0);
    nextCycle();
    checkEntry("ill2", OP_ADD, 32'd0, 32'd0, 1'b1);
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
`ifdef ALU_DECODE_STATS_EN
    checkOutput("ill_pair/issue_count", IssueCount, 32'd2);
    checkOutput("ill_pair/illegal_count", IllegalCount, 32'd2);
`else
    checkOutput("ill_pair/issue_count", IssueCount, 32'd0);
    checkOutput("ill_pair/illegal_count", IllegalCount, 32'd0);
`endif

    // Randomized traffic, checked against the behavioural model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom();
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom());
      endcase
      r[31:25] = f7;
      r[14:12] = 3'($urandom());
      r[6:0]   = ($urandom_range(0, 10) == 10) ? 7'($urandom()) : opcs[$urandom_range(0, 9)];
      applyStimulus(r, $urandom(), $urandom(), $urandom(), $urandom(),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
      #1;
      checkOutput("rand/in_ready", 32'(InReady), 32'(!m_valid || OutReady));
      nextCycle();
      checkOutput("rand/valid", 32'(OutValid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("rand/op", 32'(ALUControlE), 32'(m_op));
        checkOutput("rand/srca", SrcAE, m_a);
        checkOutput("rand/srcb", SrcBE, m_b);
        checkOutput("rand/illegal", 32'(IllegalE), 32'(m_ill));
      end
      checkCounters("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
